// File: rtl/cmd_cfg_pkg.sv
// cmd_cfg_pkg: opcodes, response codes and FSM encodings shared by cmd_cfg_multi.
package cmd_cfg_pkg;
    typedef enum logic [1:0] {READ = 2'b00, WRITE = 2'b01, DUMP = 2'b10, RSVD = 2'b11} op_t;
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;
    typedef logic [2:0] state_t;
    localparam state_t IDLE      = 3'd0;
    localparam state_t WAIT_SENT = 3'd1;
    localparam state_t DUMP_RD   = 3'd2;
    localparam state_t DUMP_SEND = 3'd3;
    localparam state_t DUMP_WAIT = 3'd4;
endpackage

// File: rtl/cmd_cfg_multi.sv
// cmd_cfg_multi: host command decoder, byte register file and oldest-first capture RAM dump.
module cmd_cfg_multi
    import cmd_cfg_pkg::*;
#(
    parameter int NUM_CH    = 5,
    parameter int DEPTH     = 384,
    parameter int AW        = 9,
    parameter int NUM_REGS  = 17,
    parameter int TRIG_ADDR = 0,
    parameter logic [NUM_REGS*8-1:0] RST_VEC = {NUM_REGS{8'h00}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           cmd,
    input  logic                  cmd_rdy,
    output logic                  clr_cmd_rdy,
    output logic [7:0]            resp,
    output logic                  send_resp,
    input  logic                  resp_sent,
    input  logic                  set_capture_done,
    input  logic [AW-1:0]         waddr,
    input  logic [NUM_CH*8-1:0]   rdata,
    output logic [AW-1:0]         addr_ptr,
    output logic [NUM_REGS*8-1:0] cfg_regs
);
    localparam int CW = $clog2(DEPTH + 1);
    op_t           op;
    logic [5:0]    addr;
    logic [7:0]    data;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    ch_idx;
    logic          accept, reg_ok, ch_ok;
    logic [7:0]    rd_byte, ch_byte;
    assign op     = op_t'(cmd[15:14]);
    assign addr   = cmd[13:8];
    assign data   = cmd[7:0];
    assign accept = state == IDLE && cmd_rdy;
    assign reg_ok = {1'b0, addr} < 7'(NUM_REGS);
    assign ch_ok  = addr != 6'd0 && addr <= 6'(NUM_CH);
    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NUM_REGS; i++) if (addr == 6'(i)) rd_byte = cfg_regs[8*i+:8];
    end
    always_comb begin
        ch_byte = '0;
        for (int i = 0; i < NUM_CH; i++) if (ch_idx == 6'(i)) ch_byte = rdata[8*i+:8];
    end
    // capture_done wins over a same-cycle host write by OR-ing bit 5 into the written data
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [7:0] r;
        logic       we, cd;
        assign we = accept && op == WRITE && addr == 6'(i);
        assign cd = i == TRIG_ADDR && set_capture_done;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r <= RST_VEC[8*i+:8];
            else if (we || cd) r <= (we ? data : r) | (cd ? 8'h20 : 8'h00);
        assign cfg_regs[8*i+:8] = r;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            resp        <= '0;
            send_resp   <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            addr_ptr    <= '0;
            cnt         <= '0;
            ch_idx      <= '0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            case (state)
                IDLE: if (cmd_rdy) begin
                    clr_cmd_rdy <= 1'b1;
                    if (op == DUMP && ch_ok) begin
                        addr_ptr <= waddr;
                        ch_idx   <= addr - 6'd1;
                        cnt      <= '0;
                        state    <= DUMP_RD;
                    end else begin
                        resp      <= (op == READ && reg_ok) ? rd_byte : (op == WRITE && reg_ok) ? ACK : NAK;
                        send_resp <= 1'b1;
                        state     <= WAIT_SENT;
                    end
                end
                WAIT_SENT: if (resp_sent) state <= IDLE;
                DUMP_RD:   state <= DUMP_SEND;
                DUMP_SEND: begin
                    resp      <= ch_byte;
                    send_resp <= 1'b1;
                    state     <= DUMP_WAIT;
                end
                DUMP_WAIT: if (resp_sent) begin
                    // a pending host command aborts the dump before the next byte
                    if (cmd_rdy) state <= IDLE;
                    else begin
                        cnt      <= cnt + 1'b1;
                        addr_ptr <= (addr_ptr == AW'(DEPTH - 1)) ? '0 : addr_ptr + 1'b1;
                        state    <= (cnt == CW'(DEPTH - 1)) ? IDLE : DUMP_RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_cfg_multi.sv
// tb_cmd_cfg_multi: directed bench for cmd_cfg_multi with a sync RAM model and a UART responder.
module tb_cmd_cfg_multi;
    localparam int NUM_CH = 5, DEPTH = 384, AW = 9, NUM_REGS = 17;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic cmd_rdy = 1'b0, resp_sent = 1'b0, set_capture_done = 1'b0;
    logic clr_cmd_rdy, send_resp;
    logic [7:0] resp;
    logic [AW-1:0] waddr = '0, addr_ptr;
    logic [NUM_CH*8-1:0] rdata;
    logic [NUM_REGS*8-1:0] cfg_regs, exp_regs;
    logic [7:0] mem [NUM_CH][DEPTH];
    logic [7:0] rx_q[$];
    logic [AW-1:0] aq[$];
    int pend = 0, passed = 0, total = 0;

    always #5 clk = ~clk;

    cmd_cfg_multi #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .AW(AW), .NUM_REGS(NUM_REGS), .TRIG_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent), .set_capture_done(set_capture_done),
        .waddr(waddr), .rdata(rdata), .addr_ptr(addr_ptr), .cfg_regs(cfg_regs)
    );

    always @(posedge clk) for (int c = 0; c < NUM_CH; c++) rdata[8*c+:8] <= mem[c][addr_ptr];

    // UART model: log each byte, acknowledge it two cycles later
    always @(negedge clk) begin
        resp_sent = 1'b0;
        if (pend > 0) begin
            pend--;
            resp_sent = (pend == 0);
        end
        if (send_resp) begin
            total++;
            if (pend != 0) $display("FAIL double_send_resp pend=%0d exp=0", pend); else passed++;
            rx_q.push_back(resp);
            aq.push_back(addr_ptr);
            pend = 2;
        end
    end

    task automatic send_cmd(input logic [15:0] c);
        @(negedge clk);
        cmd = c;
        cmd_rdy = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (clr_cmd_rdy) break;
        end
        cmd_rdy = 1'b0;
    endtask

    task automatic do_cmd(input logic [15:0] c, output logic [7:0] r);
        rx_q.delete();
        r = 'x;
        send_cmd(c);
        for (int k = 0; k < 20 && rx_q.size() == 0; k++) @(negedge clk);
        if (rx_q.size() != 0) r = rx_q[0];
        repeat (4) @(negedge clk);
    endtask

    task automatic run_dump(input logic [5:0] ch);
        rx_q.delete();
        aq.delete();
        send_cmd({2'b10, ch, 8'h00});
        for (int k = 0; k < 5000 && rx_q.size() < DEPTH; k++) @(negedge clk);
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (resp !== 8'h00) $display("FAIL rst_resp got=%h exp=00", resp); else passed++;
        total++; if (send_resp !== 1'b0) $display("FAIL rst_send_resp got=%b exp=0", send_resp); else passed++;
        total++; if (clr_cmd_rdy !== 1'b0) $display("FAIL rst_clr got=%b exp=0", clr_cmd_rdy); else passed++;
        total++; if (addr_ptr !== '0) $display("FAIL rst_addr_ptr got=%0d exp=0", addr_ptr); else passed++;
        total++; if (cfg_regs !== '0) $display("FAIL rst_cfg got=%h exp=0", cfg_regs); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_regs();
        logic [7:0] r;
        for (int i = 0; i < NUM_REGS; i++) begin
            do_cmd({2'b01, 6'(i), 8'(i + 1)}, r);
            exp_regs[8*i+:8] = 8'(i + 1);
            total++; if (r !== 8'hA5) $display("FAIL wr%0d got=%h exp=a5", i, r); else passed++;
        end
        total++; if (cfg_regs !== exp_regs) $display("FAIL cfg_after_wr got=%h exp=%h", cfg_regs, exp_regs); else passed++;
        for (int i = 0; i < NUM_REGS; i++) begin
            do_cmd({2'b00, 6'(i), 8'h00}, r);
            total++; if (r !== 8'(i + 1)) $display("FAIL rd%0d got=%h exp=%h", i, r, 8'(i + 1)); else passed++;
        end
        do_cmd({2'b00, 6'd17, 8'h00}, r);
        total++; if (r !== 8'hEE) $display("FAIL rd17 got=%h exp=ee", r); else passed++;
        do_cmd({2'b01, 6'd17, 8'h55}, r);
        total++; if (r !== 8'hEE) $display("FAIL wr17 got=%h exp=ee", r); else passed++;
        do_cmd({2'b00, 6'd63, 8'h00}, r);
        total++; if (r !== 8'hEE) $display("FAIL rd63 got=%h exp=ee", r); else passed++;
        total++; if (cfg_regs !== exp_regs) $display("FAIL cfg_after_nak got=%h exp=%h", cfg_regs, exp_regs); else passed++;
    endtask

    task automatic test_dump_all();
        int bad;
        for (int c = 0; c < NUM_CH; c++) for (int i = 0; i < DEPTH; i++) mem[c][i] = 8'(i);
        waddr = '0;
        for (int ch = 1; ch <= NUM_CH; ch++) begin
            run_dump(6'(ch));
            bad = 0;
            for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] !== 8'(k) || aq[k] !== AW'(k)) bad++;
            total++;
            if (rx_q.size() != DEPTH || bad != 0) $display("FAIL dump_ch%0d n=%0d bad=%0d exp n=384 bad=0", ch, rx_q.size(), bad);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        int bad;
        for (int c = 0; c < NUM_CH; c++) for (int i = 0; i < DEPTH; i++) mem[c][i] = 8'(i * 3 + c * 40);
        waddr = AW'(383);
        run_dump(6'd3);
        total++; if (rx_q.size() != DEPTH) $display("FAIL wrap_count got=%0d exp=384", rx_q.size()); else passed++;
        if (rx_q.size() >= 2) begin
            total++; if (rx_q[0] !== 8'hCD) $display("FAIL wrap_byte0 got=%h exp=cd", rx_q[0]); else passed++;
            total++; if (rx_q[1] !== 8'h50) $display("FAIL wrap_byte1 got=%h exp=50", rx_q[1]); else passed++;
            total++; if (aq[0] !== AW'(383) || aq[1] !== '0) $display("FAIL wrap_ptr got=%0d,%0d exp=383,0", aq[0], aq[1]); else passed++;
        end
        bad = 0;
        for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] !== 8'(((383 + k) % DEPTH) * 3 + 80)) bad++;
        total++; if (bad != 0) $display("FAIL wrap_bytes bad=%0d exp=0", bad); else passed++;
        total++; if (addr_ptr !== AW'(383)) $display("FAIL wrap_end_ptr got=%0d exp=383", addr_ptr); else passed++;
    endtask

    task automatic test_nak();
        logic [7:0] r;
        do_cmd({2'b10, 6'd0, 8'h00}, r);
        total++; if (r !== 8'hEE) $display("FAIL dump_ch0 got=%h exp=ee", r); else passed++;
        total++; if (addr_ptr !== AW'(383)) $display("FAIL ch0_ptr got=%0d exp=383", addr_ptr); else passed++;
        do_cmd({2'b10, 6'd6, 8'h00}, r);
        total++; if (r !== 8'hEE || rx_q.size() != 1) $display("FAIL dump_ch6 got=%h n=%0d exp=ee n=1", r, rx_q.size()); else passed++;
        total++; if (addr_ptr !== AW'(383)) $display("FAIL ch6_ptr got=%0d exp=383", addr_ptr); else passed++;
        do_cmd({2'b11, 6'd1, 8'h00}, r);
        total++; if (r !== 8'hEE) $display("FAIL op11 got=%h exp=ee", r); else passed++;
    endtask

    task automatic test_abort();
        int bad;
        rx_q.delete();
        waddr = AW'(10);
        send_cmd({2'b10, 6'd2, 8'h00});
        for (int k = 0; k < 200 && rx_q.size() < 10; k++) @(negedge clk);
        cmd = {2'b00, 6'd6, 8'h00};
        cmd_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (clr_cmd_rdy) break;
        end
        cmd_rdy = 1'b0;
        repeat (40) @(negedge clk);
        total++; if (rx_q.size() != 11) $display("FAIL abort_count got=%0d exp=11", rx_q.size()); else passed++;
        bad = 0;
        for (int k = 0; k < 10 && k < rx_q.size(); k++) if (rx_q[k] !== 8'((10 + k) * 3 + 40)) bad++;
        total++; if (bad != 0) $display("FAIL abort_bytes bad=%0d exp=0", bad); else passed++;
        if (rx_q.size() == 11) begin
            total++; if (rx_q[10] !== 8'h07) $display("FAIL abort_read got=%h exp=07", rx_q[10]); else passed++;
        end
    endtask

    task automatic test_capture_done();
        logic [7:0] r;
        rx_q.delete();
        @(negedge clk);
        cmd = 16'h4003;
        cmd_rdy = 1'b1;
        set_capture_done = 1'b1;
        @(negedge clk);
        set_capture_done = 1'b0;
        total++; if (clr_cmd_rdy !== 1'b1) $display("FAIL cd_clr got=%b exp=1", clr_cmd_rdy); else passed++;
        cmd_rdy = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (cfg_regs[7:0] !== 8'h23) $display("FAIL cd_trig got=%h exp=23", cfg_regs[7:0]); else passed++;
        total++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) $display("FAIL cd_ack n=%0d exp n=1 a5", rx_q.size()); else passed++;
        do_cmd(16'h4000, r);
        total++; if (cfg_regs[7:0] !== 8'h00) $display("FAIL trig_clear got=%h exp=00", cfg_regs[7:0]); else passed++;
        set_capture_done = 1'b1;
        @(negedge clk);
        set_capture_done = 1'b0;
        total++; if (cfg_regs[15:0] !== 16'h0220) $display("FAIL cd_only got=%h exp=0220", cfg_regs[15:0]); else passed++;
        do_cmd(16'h0000, r);
        total++; if (r !== 8'h20) $display("FAIL rd_trig got=%h exp=20", r); else passed++;
    endtask

    task automatic test_reset_mid_dump();
        logic [7:0] r;
        rx_q.delete();
        waddr = '0;
        send_cmd({2'b10, 6'd1, 8'h00});
        for (int k = 0; k < 200 && rx_q.size() < 5; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (resp !== 8'h00 || send_resp !== 1'b0 || clr_cmd_rdy !== 1'b0)
            $display("FAIL mid_rst_out got=%h,%b,%b exp=00,0,0", resp, send_resp, clr_cmd_rdy); else passed++;
        total++; if (addr_ptr !== '0) $display("FAIL mid_rst_ptr got=%0d exp=0", addr_ptr); else passed++;
        total++; if (cfg_regs !== '0) $display("FAIL mid_rst_cfg got=%h exp=0", cfg_regs); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        repeat (20) @(negedge clk);
        total++; if (rx_q.size() != 0) $display("FAIL mid_rst_bytes got=%0d exp=0", rx_q.size()); else passed++;
        do_cmd({2'b00, 6'd3, 8'h00}, r);
        total++; if (r !== 8'h00 || rx_q.size() != 1) $display("FAIL post_rst_rd got=%h n=%0d exp=00 n=1", r, rx_q.size()); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        exp_regs = '0;
        test_reset();
        test_regs();
        test_dump_all();
        test_wrap();
        test_nak();
        test_abort();
        test_capture_done();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
